// File: rtl/dac_pkg.sv
// dac_pkg: shared DAC datapath width and interpolator state encoding
package dac_pkg;
   localparam int DAC_DW = 24;
   typedef enum logic [1:0] {
      S_EMPTY     = 2'd0,
      S_WAIT_IN   = 2'd1,
      S_WAIT_HALF = 2'd2
   } interp_state_t;
endpackage

// File: rtl/interp_avg2.sv
// interp_avg2: combinational signed average of two samples, floor by default
// INTERP_ROUND_EN rounds half toward +inf instead
module interp_avg2
   import dac_pkg::*;
#(
   parameter int DW = DAC_DW
) (
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic signed [DW-1:0] y
);
   logic signed [DW:0] s;
`ifdef INTERP_ROUND_EN
   assign s = (DW+1)'(a) + (DW+1)'(b) + (DW+1)'(1);
`else
   assign s = (DW+1)'(a) + (DW+1)'(b);
`endif
   assign y = DW'(s >>> 1);
endmodule

// File: rtl/interp_lin_x2.sv
// interp_lin_x2: stereo x2 linear-interpolation upsampler driven by in/out rate strobes
// INTERP_ROUND_EN selects rounded midpoints in interp_avg2
module interp_lin_x2
   import dac_pkg::*;
#(
   parameter int DW = DAC_DW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_en,
   input  logic                 out_en,
   input  logic signed [DW-1:0] in_l,
   input  logic signed [DW-1:0] in_r,
   output logic signed [DW-1:0] out_l,
   output logic signed [DW-1:0] out_r,
   output logic                 out_valid,
   output logic                 sync_err
);
   interp_state_t        state_q, state_d;
   logic signed [DW-1:0] cur_l, cur_r, cur_l_d, cur_r_d;
   logic signed [DW-1:0] out_l_d, out_r_d, mid_l, mid_r;
   logic                 valid_d, err_d;

   interp_avg2 #(.DW(DW)) u_avg_l (.a(cur_l), .b(in_l), .y(mid_l));
   interp_avg2 #(.DW(DW)) u_avg_r (.a(cur_r), .b(in_r), .y(mid_r));

   // cur is zero while empty, so the first midpoint blends against zero history
   always_comb begin
      state_d = state_q;
      cur_l_d = in_en ? in_l : cur_l;
      cur_r_d = in_en ? in_r : cur_r;
      out_l_d = out_l;
      out_r_d = out_r;
      valid_d = 1'b0;
      err_d   = sync_err;
      case (state_q)
         S_EMPTY: begin
            if (in_en && out_en) begin
               out_l_d = mid_l;
               out_r_d = mid_r;
               valid_d = 1'b1;
               state_d = S_WAIT_HALF;
            end else if (out_en) begin
               out_l_d = '0;
               out_r_d = '0;
               valid_d = 1'b1;
            end else if (in_en) begin
               err_d   = 1'b1;
               state_d = S_WAIT_HALF;
            end
         end
         S_WAIT_IN: begin
            if (in_en && out_en) begin
               out_l_d = mid_l;
               out_r_d = mid_r;
               valid_d = 1'b1;
               state_d = S_WAIT_HALF;
            end else if (out_en) begin
               out_l_d = cur_l;
               out_r_d = cur_r;
               valid_d = 1'b1;
               err_d   = 1'b1;
            end else if (in_en) begin
               err_d   = 1'b1;
               state_d = S_WAIT_HALF;
            end
         end
         S_WAIT_HALF: begin
            if (in_en && out_en) begin
               out_l_d = mid_l;
               out_r_d = mid_r;
               valid_d = 1'b1;
               err_d   = 1'b1;
            end else if (out_en) begin
               out_l_d = cur_l;
               out_r_d = cur_r;
               valid_d = 1'b1;
               state_d = S_WAIT_IN;
            end else if (in_en) begin
               err_d   = 1'b1;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_EMPTY;
         cur_l     <= '0;
         cur_r     <= '0;
         out_l     <= '0;
         out_r     <= '0;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_l     <= cur_l_d;
         cur_r     <= cur_r_d;
         out_l     <= out_l_d;
         out_r     <= out_r_d;
         out_valid <= valid_d;
         sync_err  <= err_d;
      end
   end
endmodule
